// File: rtl/crc_port_arbiter.sv
// Packet-level round-robin arbiter sharing one CRC append stage between PORT_NUM ingress ports.
// Optional idle-beat watchdog is built when CRC_ARB_TIMEOUT_EN is defined.
module crc_port_arbiter #(
  parameter int unsigned PORT_NUM       = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           iClk,
  input  logic                           iRst_n,
  input  logic [PORT_NUM-1:0]            iReq,
  input  logic [PORT_NUM-1:0]            iSop,
  input  logic [PORT_NUM-1:0]            iEop,
  input  logic [PORT_NUM-1:0]            iVld,
  input  logic [PORT_NUM*DATA_WIDTH-1:0] iData,
  output logic [PORT_NUM-1:0]            oReady,
  output logic [PORT_NUM-1:0]            oGrant,
  output logic                           oWrSop,
  output logic                           oWrEop,
  output logic                           oWrVld,
  output logic [DATA_WIDTH-1:0]          oWrData,
  input  logic                           iFull,
  output logic                           oTimeout
);

  localparam int unsigned IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_GAP
  } state_t;

  state_t                r_state;
  logic [PORT_NUM-1:0]   r_grant;
  logic [IDX_W-1:0]      r_gidx;
  logic [IDX_W-1:0]      r_last;

  logic                  w_found;
  logic [IDX_W-1:0]      w_pick;
  logic [IDX_W-1:0]      w_cand;
  logic                  w_xfer;
  logic                  w_sop;
  logic                  w_eop;
  logic                  w_vld;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_eop_acc;
  logic                  w_timeout;

  // Search order starts just after the last served port, so the previous winner comes last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned i = 1; i <= PORT_NUM; i++) begin
      w_cand = IDX_W'((32'(r_last) + i) % PORT_NUM);
      if (!w_found && iReq[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_xfer = (r_state == ST_XFER);

  always_comb begin
    w_sop  = 1'b0;
    w_eop  = 1'b0;
    w_vld  = 1'b0;
    w_data = '0;
    oReady = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (r_gidx == IDX_W'(p)) begin
        w_sop     = iSop[p];
        w_eop     = iEop[p];
        w_vld     = iVld[p];
        w_data    = iData[p*DATA_WIDTH +: DATA_WIDTH];
        oReady[p] = w_xfer && !iFull;
      end
    end
  end

  assign w_eop_acc = w_xfer && w_eop && !iFull;

  assign oWrSop   = w_xfer && w_sop && !iFull;
  assign oWrVld   = w_xfer && w_vld && !iFull;
  assign oWrEop   = w_eop_acc || w_timeout;
  assign oWrData  = oWrVld ? w_data : '0;
  assign oGrant   = r_grant;
  assign oTimeout = w_timeout;

`ifdef CRC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             w_none;

  assign w_none    = !(w_sop || w_eop || w_vld);
  // The abort fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
  assign w_timeout = w_xfer && !iFull && w_none && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_wd_cnt <= '0;
    end else if (!w_xfer || w_timeout) begin
      r_wd_cnt <= '0;
    end else if (!iFull) begin
      r_wd_cnt <= w_none ? r_wd_cnt + 1'b1 : '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!iRst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IDX_W'(PORT_NUM - 1);
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= {{(PORT_NUM-1){1'b0}}, 1'b1} << w_pick;
            r_gidx  <= w_pick;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_eop_acc || w_timeout) begin
            r_last  <= r_gidx;
            r_grant <= '0;
            r_state <= ST_GAP;
          end
        end
        // One spare cycle lets the CRC stage emit its CRC word before the next SOP.
        ST_GAP: begin
          if (!iFull) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_port_arbiter.sv
// Self-checking bench for crc_port_arbiter: randomized per-port packet sources checked
// cycle by cycle against a behavioural owner/gap model, plus directed scenario checks.
module tb_crc_port_arbiter;

  localparam int PN   = 4;
  localparam int DW   = 32;
  localparam int TO   = 8;
  localparam int MAXB = 6;

  logic               iClk = 1'b0;
  logic               iRst_n = 1'b1;
  logic [PN-1:0]      iReq = '0, iSop = '0, iEop = '0, iVld = '0;
  logic [PN*DW-1:0]   iData = '0;
  logic               iFull = 1'b0;
  logic [PN-1:0]      oReady, oGrant;
  logic               oWrSop, oWrEop, oWrVld, oTimeout;
  logic [DW-1:0]      oWrData;

  always #5 iClk = ~iClk;

  crc_port_arbiter #(
    .PORT_NUM      (PN),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iReq    (iReq),
    .iSop    (iSop),
    .iEop    (iEop),
    .iVld    (iVld),
    .iData   (iData),
    .oReady  (oReady),
    .oGrant  (oGrant),
    .oWrSop  (oWrSop),
    .oWrEop  (oWrEop),
    .oWrVld  (oWrVld),
    .oWrData (oWrData),
    .iFull   (iFull),
    .oTimeout(oTimeout)
  );

  typedef struct packed {
    logic [PN-1:0] grant;
    logic [PN-1:0] ready;
    logic          sop;
    logic          eop;
    logic          vld;
    logic [DW-1:0] data;
    logic          to;
  } obs_t;

  int checks = 0;
  int errors = 0;

  // ---------------- packet sources ----------------
  bit          src_act    [PN];
  bit          src_rep    [PN];
  bit          src_silent [PN];
  bit          src_junk   [PN];
  int          src_len    [PN];
  int          src_pos    [PN];
  logic [DW-1:0] src_dat  [PN][MAXB];
  int          pkts_start [PN];
  int          pkts_done  [PN];
  int          aborted;
  logic        full_drv = 1'b0;
  int          gap_pct  = 0;
  obs_t        s_obs, e_obs;

  // ---------------- behavioural reference ----------------
  // Model: which port (if any) owns the CRC stage, whether the post-packet gap is pending,
  // and who was served last.
  int   m_owner = -1;
  bit   m_gap   = 1'b0;
  int   m_last  = PN - 1;
  int   m_idle  = 0;
  obs_t e_now;

  function automatic int pick(int last, logic [PN-1:0] req);
    for (int k = 1; k <= PN; k++) begin
      if (req[(last + k) % PN]) return (last + k) % PN;
    end
    return -1;
  endfunction

  always_comb begin
    e_now = '0;
    if (m_owner >= 0) begin
      e_now.grant[m_owner] = 1'b1;
      if (!iFull) begin
        e_now.ready[m_owner] = 1'b1;
        e_now.sop = iSop[m_owner];
        e_now.eop = iEop[m_owner];
        e_now.vld = iVld[m_owner];
        if (iVld[m_owner]) e_now.data = iData[m_owner*DW +: DW];
`ifdef CRC_ARB_TIMEOUT_EN
        if (!(iSop[m_owner] || iEop[m_owner] || iVld[m_owner]) && m_idle == TO - 1) begin
          e_now.eop = 1'b1;
          e_now.to  = 1'b1;
        end
`endif
      end
    end
  end

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      m_owner <= -1;
      m_gap   <= 1'b0;
      m_last  <= PN - 1;
      m_idle  <= 0;
    end else if (m_owner >= 0) begin
      if (e_now.eop) begin
        m_last  <= m_owner;
        m_owner <= -1;
        m_gap   <= 1'b1;
        m_idle  <= 0;
      end else if (!iFull) begin
        m_idle <= (iSop[m_owner] || iEop[m_owner] || iVld[m_owner]) ? 0 : m_idle + 1;
      end
    end else if (m_gap) begin
      if (!iFull) m_gap <= 1'b0;
    end else if (iReq != '0) begin
      m_owner <= pick(m_last, iReq);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_pkt(input int p, input int len);
    src_act[p]    = 1'b1;
    src_silent[p] = 1'b0;
    src_len[p]    = len;
    src_pos[p]    = 0;
    for (int b = 0; b < MAXB; b++) src_dat[p][b] = $urandom() & 32'h7FFF_FFFF;
    pkts_start[p]++;
  endtask

  task automatic clear_sources();
    for (int p = 0; p < PN; p++) begin
      src_act[p] = 0; src_rep[p] = 0; src_silent[p] = 0; src_junk[p] = 0;
      src_len[p] = 0; src_pos[p] = 0; pkts_start[p] = 0; pkts_done[p] = 0;
    end
    aborted  = 0;
    full_drv = 1'b0;
    gap_pct  = 0;
    iReq = '0; iSop = '0; iEop = '0; iVld = '0; iData = '0; iFull = 1'b0;
  endtask

  task automatic do_reset();
    clear_sources();
    iRst_n = 1'b0;
    repeat (2) @(posedge iClk);
    #1 iRst_n = 1'b1;
  endtask

  // One clock: drive sources, snapshot DUT and model at the falling edge, advance sources.
  task automatic step();
    logic [PN-1:0]    rq, sp, ep, vl, acc;
    logic [PN*DW-1:0] dt;
    rq = '0; sp = '0; ep = '0; vl = '0; dt = '0; acc = '0;
    for (int p = 0; p < PN; p++) begin
      if (src_junk[p]) begin
        int r;
        r = $urandom_range(0, 2);
        sp[p] = (r == 1);
        vl[p] = (r == 2);
        dt[p*DW +: DW] = '1;
      end else if (src_act[p]) begin
        rq[p] = 1'b1;
        if (src_pos[p] == 0) sp[p] = 1'b1;
        else if (src_silent[p] || (!full_drv && $urandom_range(0, 99) < gap_pct)) begin
          sp[p] = 1'b0;
        end else if (src_pos[p] <= src_len[p]) begin
          vl[p] = 1'b1;
          dt[p*DW +: DW] = src_dat[p][src_pos[p]-1];
        end else ep[p] = 1'b1;
      end
    end
    iReq = rq; iSop = sp; iEop = ep; iVld = vl; iData = dt; iFull = full_drv;
    @(negedge iClk);
    s_obs.grant = oGrant;  s_obs.ready = oReady;
    s_obs.sop   = oWrSop;  s_obs.eop   = oWrEop;  s_obs.vld = oWrVld;
    s_obs.data  = oWrData; s_obs.to    = oTimeout;
    e_obs = e_now;
    for (int p = 0; p < PN; p++) acc[p] = oReady[p] && (iSop[p] || iEop[p] || iVld[p]);
    @(posedge iClk);
    #1;
    for (int p = 0; p < PN; p++) begin
      if (s_obs.to && s_obs.grant[p] && src_act[p]) begin
        src_act[p] = 0; src_silent[p] = 0; aborted++;
      end else if (acc[p] && src_act[p] && !src_junk[p]) begin
        if (src_pos[p] == src_len[p] + 1) begin
          pkts_done[p]++;
          src_act[p] = 0;
          if (src_rep[p]) load_pkt(p, src_len[p]);
        end else src_pos[p]++;
      end
    end
  endtask

  function automatic bit any_active();
    for (int p = 0; p < PN; p++) if (src_act[p]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_sources();
    #2 iRst_n = 1'b0;
    iReq = '1; iSop = '1;
    repeat (2) @(posedge iClk);
    #2;
    checks++;
    if ({oGrant, oReady, oWrSop, oWrEop, oWrVld, oWrData, oTimeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b ready=%b sop=%b eop=%b vld=%b data=%h to=%b want all 0",
               oGrant, oReady, oWrSop, oWrEop, oWrVld, oWrData, oTimeout);
    end
    @(posedge iClk);
    #1 iRst_n = 1'b1;
    iReq = '0; iSop = '0;
    step();
    checks++;
    if (s_obs !== obs_t'(0) || s_obs !== e_obs) begin
      errors++;
      $display("FAIL reset_idle got=%h want=%h", s_obs, e_obs);
    end
  endtask

  task automatic test_single_port();
    obs_t ex;
    do_reset();
    load_pkt(0, 2);
    src_dat[0][0] = 32'h1111_1111;
    src_dat[0][1] = 32'h2222_2222;
    for (int i = 1; i <= 7; i++) begin
      step();
      ex = '0;
      if (i >= 2 && i <= 5) begin
        ex.grant = 4'b0001;
        ex.ready = 4'b0001;
      end
      case (i)
        2: ex.sop = 1'b1;
        3: begin ex.vld = 1'b1; ex.data = 32'h1111_1111; end
        4: begin ex.vld = 1'b1; ex.data = 32'h2222_2222; end
        5: ex.eop = 1'b1;
        default: ;
      endcase
      checks++;
      if (s_obs !== ex) begin
        errors++;
        $display("FAIL single_cycle%0d got=%h want=%h", i, s_obs, ex);
      end
      checks++;
      if (s_obs !== e_obs) begin
        errors++;
        $display("FAIL single_model%0d got=%h want=%h", i, s_obs, e_obs);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [PN-1:0] seq[$];
    logic [PN-1:0] prev_g, want[4];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b1000; want[3] = 4'b0001;
    do_reset();
    foreach (want[k]) prev_g = 0;
    for (int p = 0; p < PN; p++) if (p != 2) begin src_rep[p] = 1; load_pkt(p, 2); end
    for (int c = 0; c < 100 && seq.size() < 4; c++) begin
      step();
      checks++;
      if (s_obs !== e_obs) begin
        errors++;
        $display("FAIL rr_model got=%h want=%h", s_obs, e_obs);
      end
      if (s_obs.grant != 0 && prev_g == 0) seq.push_back(s_obs.grant);
      prev_g = s_obs.grant;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= seq.size() || seq[k] !== want[k]) begin
        errors++;
        $display("FAIL rr_grant%0d got=%b want=%b", k, (k < seq.size()) ? seq[k] : 4'bx, want[k]);
      end
    end
    for (int p = 0; p < PN; p++) src_rep[p] = 0;
    for (int c = 0; c < 100 && any_active(); c++) begin
      step();
      checks++;
      if (s_obs !== e_obs) begin
        errors++;
        $display("FAIL rr_drain got=%h want=%h", s_obs, e_obs);
      end
    end
    checks++;
    if (any_active()) begin
      errors++;
      $display("FAIL rr_drain_timeout got=active want=idle");
    end
  endtask

  task automatic test_backpressure();
    int  stall_left, post_full, dead_cnt;
    bit  stall_done, loaded0;
    do_reset();
    load_pkt(2, 2);
    src_dat[2][1] = 32'hDEAD_BEEF;
    stall_left = 0; post_full = 0; dead_cnt = 0; stall_done = 0; loaded0 = 0;
    for (int c = 0; c < 80; c++) begin
      if (!stall_done && m_owner == 2 && src_pos[2] == 2) begin
        stall_left = 3;
        stall_done = 1;
      end
      full_drv = (stall_left > 0) || (post_full > 0);
      step();
      checks++;
      if (s_obs !== e_obs) begin
        errors++;
        $display("FAIL bp_model got=%h want=%h", s_obs, e_obs);
      end
      if (stall_left > 0) begin
        checks++;
        if (s_obs.ready[2] !== 1'b0 || s_obs.vld !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall got ready2=%b vld=%b want 0 0", s_obs.ready[2], s_obs.vld);
        end
        stall_left--;
      end
      if (post_full > 0) begin
        checks++;
        if (s_obs.grant !== '0) begin
          errors++;
          $display("FAIL bp_gap_hold got grant=%b want=0000", s_obs.grant);
        end
        post_full--;
      end
      if (s_obs.vld && s_obs.data == 32'hDEAD_BEEF) dead_cnt++;
      if (pkts_done[2] == 1 && !loaded0) begin
        loaded0   = 1;
        post_full = 2;
        load_pkt(0, 1);
      end
      if (pkts_done[0] == 1) break;
    end
    full_drv = 0;
    checks++;
    if (dead_cnt != 1) begin
      errors++;
      $display("FAIL bp_beat_once got=%0d want=1", dead_cnt);
    end
    checks++;
    if (pkts_done[0] != 1) begin
      errors++;
      $display("FAIL bp_next_pkt got=%0d want=1", pkts_done[0]);
    end
  endtask

  task automatic test_isolation();
    do_reset();
    src_junk[0] = 1;
    load_pkt(1, 3);
    for (int c = 0; c < 40 && src_act[1]; c++) begin
      step();
      checks++;
      if (s_obs !== e_obs || s_obs.data === 32'hFFFF_FFFF || s_obs.ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL iso_cycle got=%h want=%h", s_obs, e_obs);
      end
    end
    src_junk[0] = 0;
    checks++;
    if (pkts_done[1] != 1) begin
      errors++;
      $display("FAIL iso_done got=%0d want=1", pkts_done[1]);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    load_pkt(2, 1);
    for (int c = 0; c < 20 && src_act[2]; c++) step();
    load_pkt(1, 3);
    for (int c = 0; c < 20 && src_pos[1] < 2; c++) step();
    checks++;
    if (src_pos[1] != 2 || oGrant !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_setup got pos=%0d grant=%b want 2 0010", src_pos[1], oGrant);
    end
    iRst_n = 1'b0;
    #2;
    checks++;
    if ({oGrant, oReady, oWrSop, oWrEop, oWrVld, oWrData, oTimeout} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got grant=%b ready=%b sop=%b eop=%b vld=%b data=%h want all 0",
               oGrant, oReady, oWrSop, oWrEop, oWrVld, oWrData);
    end
    clear_sources();
    @(posedge iClk);
    #1 iRst_n = 1'b1;
    load_pkt(0, 1);
    load_pkt(3, 1);
    step();
    step();
    checks++;
    if (s_obs.grant !== 4'b0001 || s_obs !== e_obs) begin
      errors++;
      $display("FAIL rstmid_first_winner got=%b want=0001", s_obs.grant);
    end
    for (int c = 0; c < 40 && any_active(); c++) step();
  endtask

  task automatic test_random();
    int started, done;
    do_reset();
    gap_pct = 20;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < PN; p++)
        if (!src_act[p] && $urandom_range(0, 9) == 0) load_pkt(p, $urandom_range(0, 4));
      full_drv = ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if (s_obs !== e_obs) begin
        errors++;
        $display("FAIL rand_model cyc%0d got=%h want=%h", c, s_obs, e_obs);
      end
    end
    full_drv = 0;
    for (int c = 0; c < 300 && any_active(); c++) begin
      step();
      checks++;
      if (s_obs !== e_obs) begin
        errors++;
        $display("FAIL rand_drain got=%h want=%h", s_obs, e_obs);
      end
    end
    started = 0; done = 0;
    for (int p = 0; p < PN; p++) begin
      started += pkts_start[p];
      done    += pkts_done[p];
    end
    checks++;
    if (started != done || started == 0) begin
      errors++;
      $display("FAIL rand_completion got=%0d want=%0d", done, started);
    end
  endtask

`ifdef CRC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    load_pkt(0, 2);
    src_silent[0] = 1;
    for (int i = 1; i <= 13; i++) begin
      if (i == 3) load_pkt(1, 1);
      step();
      checks++;
      if (s_obs !== e_obs) begin
        errors++;
        $display("FAIL to_model%0d got=%h want=%h", i, s_obs, e_obs);
      end
      checks++;
      if (s_obs.to !== (i == 10) || (i == 10 && s_obs.eop !== 1'b1)) begin
        errors++;
        $display("FAIL to_pulse%0d got to=%b eop=%b want to=%b", i, s_obs.to, s_obs.eop, i == 10);
      end
      if (i == 11 || i == 12) begin
        checks++;
        if (s_obs.grant !== '0) begin
          errors++;
          $display("FAIL to_gap%0d got=%b want=0000", i, s_obs.grant);
        end
      end
      if (i == 13) begin
        checks++;
        if (s_obs.grant !== 4'b0010) begin
          errors++;
          $display("FAIL to_next_grant got=%b want=0010", s_obs.grant);
        end
      end
    end
    for (int c = 0; c < 20 && any_active(); c++) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_isolation();
    test_reset_mid_packet();
    test_random();
`ifdef CRC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit got=expired want=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/crc_port_arbiter.md
# crc_port_arbiter

Packet-level round-robin arbiter sharing one CRC append stage (and the unpack FIFO behind it) between `PORT_NUM` ingress requesters. It grants one port for a whole packet, from its SOP cycle through its EOP cycle, muxes that port's beats onto the CRC-stage write interface, and propagates the CRC stage's full/backpressure signal back to the granted port only. Sits between the per-port ingress buffers and the CRC data-send stage.

## Interface
- `PORT_NUM`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 32: beat width.
- `TIMEOUT_CYCLES`, 1024: idle-beat limit for the watchdog (used only with the macro).
- `iClk` input 1: clock; all logic on rising edge.
- `iRst_n` input 1: asynchronous, active-low reset.
- `iReq` input PORT_NUM: port p holds a packet; held high until its EOP is accepted.
- `iSop`/`iEop`/`iVld` input PORT_NUM each: per-port SOP cycle, EOP cycle, data beat.
- `iData` input PORT_NUM*DATA_WIDTH: port p at `[p*DATA_WIDTH +: DATA_WIDTH]`.
- `oReady` output PORT_NUM: a cycle of port p is accepted when it presents SOP, EOP or VLD and `oReady[p]`=1.
- `oGrant` output PORT_NUM: one-hot registered grant; 0 when idle.
- `oWrSop`/`oWrEop`/`oWrVld` output 1: to the CRC stage.
- `oWrData` output DATA_WIDTH: to the CRC stage; 0 when `oWrVld`=0.
- `iFull` input 1: CRC stage full/backpressure; no cycle is forwarded while high.
- `oTimeout` output 1: one-cycle pulse on a watchdog abort.

## Operation
- Packet format per port: one SOP cycle (vld=0), ≥0 VLD beats, one EOP cycle (vld=0). Cycles carry at most one of SOP/EOP/VLD.
- FSM states: IDLE, XFER, GAP.
- IDLE: if `iReq`≠0, select the first requesting port after `rLast` in the order rLast+1, rLast+2, …, wrapping at PORT_NUM-1 to 0. Register the selection into `oGrant` and go to XFER. Otherwise stay in IDLE.
- XFER, with g = the granted port: `oReady[g]` = !iFull, and all other `oReady` bits are 0. `oWrSop` = iSop[g]&&!iFull, and likewise for `oWrEop`/`oWrVld`. `oWrData` = iData[g] when `oWrVld`, else 0. Inputs from non-granted ports are ignored.
- When EOP on g is accepted: `rLast` <= g, `oGrant` <= 0, and the FSM goes to GAP.
- GAP: held for a minimum of 1 cycle, so the CRC stage can emit its CRC word. Go to IDLE on the first cycle `iFull`=0, and stay in GAP while `iFull`=1.
- `iReq[g]` dropping mid-packet does not release the grant. Only an accepted EOP releases it, or a watchdog abort when the macro is enabled.

## Timing
- Reset values: state IDLE, `oGrant`=0, `rLast`=PORT_NUM-1 (port 0 wins first), `oReady`=0, `oWrSop/Eop/Vld`=0, `oWrData`=0, `oTimeout`=0. Watchdog counter is 0.
- A reset asserted mid-packet aborts immediately. No EOP is emitted.
- Grant latency: `iReq` rises in cycle n and `oGrant` is set in cycle n+1. The earliest forwarded SOP is in cycle n+1.
- Forwarding is combinational from inputs to outputs, with zero latency in XFER.
- Back-to-back packets: EOP is accepted in cycle t, GAP is cycle t+1, IDLE is cycle t+2, and the next grant is in cycle t+3. This holds with `iFull`=0 throughout.
- `iFull` asserted in any cycle means that cycle is not accepted. The port holds its SOP/EOP/VLD and data until it is accepted.

## Configuration
- `CRC_ARB_TIMEOUT_EN` defined:
  - A counter increments during XFER on cycles where g presents none of SOP/EOP/VLD. Cycles stalled by `iFull` do not count.
  - The counter clears to 0 on any accepted cycle.
  - When it reaches `TIMEOUT_CYCLES`, and `iFull`=0, the block drives a synthetic `oWrEop` for 1 cycle and pulses `oTimeout`. It then releases the grant, sets `rLast`<=g and enters GAP.
- Not defined: no counter is built, `oTimeout` is tied to 0, and `TIMEOUT_CYCLES` is unused.

## Test plan
- Single port: reset, then port 0 sends SOP, data 0x11111111 and 0x22222222, then EOP, with `iFull`=0. Required response: `oGrant`=0001 one cycle after `iReq`. The outputs forward the same 4 cycles in order with unchanged data. GAP lasts 1 cycle, then IDLE.
- Round-robin: ports 0, 1 and 3 request continuously with 2-beat packets. Grants must be 0001 → 0010 → 1000 → 0001, and no port is granted twice in a row while others wait.
- Backpressure: `iFull`=1 for 3 cycles during port 2's second data beat (0xDEADBEEF). `oReady[2]`=0 and `oWrVld`=0 during the stall. The beat is forwarded exactly once after `iFull` falls. GAP holds while `iFull`=1 after EOP.
- Isolation: port 1 is granted while port 0 toggles SOP/VLD with data 0xFFFFFFFF. `oWrData` never shows 0xFFFFFFFF, and `oReady[0]` stays 0.
- Reset mid-packet: assert `iRst_n`=0 after 1 data beat. All outputs read 0 and `oGrant`=0 immediately. After release, port 0 wins first.
- `CRC_ARB_TIMEOUT_EN`, with `TIMEOUT_CYCLES`=8: port 0 sends SOP and then goes silent. Required response: `oWrEop`=1 and `oTimeout`=1 on the 8th idle cycle, then GAP. Pending port 1 is granted next.
